// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Write side of an asynchronous FIFO shared by two packet requesters
// (requester 0 = I2C master RX, requester 1 = I2C slave RX). A small FSM
// grants the FIFO to one requester for an entire packet. Grants alternate
// round-robin when both requesters ask at the same time. Words of the owning
// requester are written straight into the FIFO memory. The block keeps the
// binary and Gray write pointers and the registered full flag.
//
// Parameters
//   addr_size  : FIFO address width, depth = 2**addr_size words (>= 2)
//   data_width : word width
//
// Ports
//   clock_i                 : single clock, rising edge
//   reset_i                 : synchronous active-high reset
//   req0_valid_i/data/last  : requester 0 word, end-of-packet marker
//   req0_ready_o            : requester 0 word accepted when valid & ready
//   req1_*                  : same for requester 1
//   read_to_write_pointer_i : Gray read pointer, already synchronized
//   write_enable_o          : FIFO memory write strobe (combinational)
//   write_address_o         : FIFO memory write address
//   write_data_o            : FIFO memory write data
//   write_pointer_o         : registered Gray write pointer
//   full_o                  : registered full flag
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int addr_size  = 3,
  parameter int data_width = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  req0_valid_i,
  input  logic [data_width-1:0] req0_data_i,
  input  logic                  req0_last_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [data_width-1:0] req1_data_i,
  input  logic                  req1_last_i,
  output logic                  req1_ready_o,
  input  logic [addr_size:0]    read_to_write_pointer_i,
  output logic                  write_enable_o,
  output logic [addr_size-1:0]  write_address_o,
  output logic [data_width-1:0] write_data_o,
  output logic [addr_size:0]    write_pointer_o,
  output logic                  full_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // The FIFO is full when the write Gray pointer equals the read Gray pointer
  // with its two most significant bits inverted.
  localparam logic [addr_size:0] full_mask_c = {2'b11, {(addr_size-1){1'b0}}};

  state_t                state_r;
  state_t                next_state_s;
  logic                  last_served_r;
  logic                  last_served_next_s;
  logic [addr_size:0]    wbin_r;
  logic [addr_size:0]    wbin_next_s;
  logic [addr_size:0]    gray_next_s;
  logic [addr_size:0]    wptr_r;
  logic                  full_r;
  logic                  accept0_s;
  logic                  accept1_s;
  logic                  accept_s;

  function automatic logic [addr_size:0] bin2gray(input logic [addr_size:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Ready is only ever offered by the owner, and is suppressed during reset
  // so that a reset cycle can never produce a write.
  assign req0_ready_o = (state_r == OWN0) & ~full_r & ~reset_i;
  assign req1_ready_o = (state_r == OWN1) & ~full_r & ~reset_i;
  assign accept0_s    = req0_valid_i & req0_ready_o;
  assign accept1_s    = req1_valid_i & req1_ready_o;
  assign accept_s     = accept0_s | accept1_s;

  assign write_enable_o  = accept_s;
  assign write_address_o = wbin_r[addr_size-1:0];
  // Data is only meaningful on accept; otherwise requester 0 data is shown.
  assign write_data_o    = accept1_s ? req1_data_i : req0_data_i;
  assign write_pointer_o = wptr_r;
  assign full_o          = full_r;

  assign wbin_next_s = wbin_r + {{addr_size{1'b0}}, accept_s};
  assign gray_next_s = bin2gray(wbin_next_s);

  // Next-state logic: packet-level ownership with round-robin tie break.
  always_comb begin
    next_state_s       = state_r;
    last_served_next_s = last_served_r;
    case (state_r)
      IDLE: begin
        // A tie goes to requester 0 only when requester 1 was served last.
        if (req0_valid_i && (!req1_valid_i || last_served_r)) begin
          next_state_s = OWN0;
        end else if (req1_valid_i) begin
          next_state_s = OWN1;
        end else begin
          next_state_s = IDLE;
        end
      end
      OWN0: begin
        // Ownership is released only by the last word, never by valid dropping.
        if (accept0_s && req0_last_i) begin
          next_state_s       = IDLE;
          last_served_next_s = 1'b0;
        end else begin
          next_state_s = OWN0;
        end
      end
      OWN1: begin
        if (accept1_s && req1_last_i) begin
          next_state_s       = IDLE;
          last_served_next_s = 1'b1;
        end else begin
          next_state_s = OWN1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, pointer and full-flag registers; reset wins over any accept.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r       <= IDLE;
      last_served_r <= 1'b1;
      wbin_r        <= '0;
      wptr_r        <= '0;
      full_r        <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      last_served_r <= last_served_next_s;
      wbin_r        <= wbin_next_s;
      wptr_r        <= gray_next_s;
      full_r        <= (gray_next_s == (read_to_write_pointer_i ^ full_mask_c));
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter addr_size, default 3: FIFO address width; depth is 2^addr_size words.
REQ-002 Parameter data_width, default 8: data word width.
REQ-003 clock_i  input  1  single clock; all logic is on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 req0_valid_i  input  1  requester 0 (I2C master RX) has a word.
REQ-006 req0_data_i  input  data_width  requester 0 word.
REQ-007 req0_last_i  input  1  requester 0 word ends its packet.
REQ-008 req0_ready_o  output  1  requester 0 word accepted when valid and ready are both high.
REQ-009 req1_valid_i, req1_data_i, req1_last_i, req1_ready_o  same as REQ-005..008, for requester 1 (I2C slave RX).
REQ-010 read_to_write_pointer_i  input  addr_size+1  Gray-coded read pointer, already synchronized into this domain.
REQ-011 write_enable_o  output  1  FIFO memory write strobe.
REQ-012 write_address_o  output  addr_size  FIFO memory write address.
REQ-013 write_data_o  output  data_width  FIFO memory write data.
REQ-014 write_pointer_o  output  addr_size+1  Gray-coded write pointer, sent to the read domain.
REQ-015 full_o  output  1  FIFO full flag, registered.

Function
REQ-016 The block SHALL hold a binary write pointer wbin[addr_size:0] and present write_pointer_o = registered Gray(wbin), where Gray(x) = x ^ (x>>1).
REQ-017 State machine states SHALL be IDLE, OWN0 and OWN1, plus a 1-bit last_served register.
REQ-018 In IDLE, both ready outputs SHALL be 0 and no write SHALL occur.
REQ-019 In IDLE, if exactly one valid is high, the next state SHALL be OWN of that requester.
REQ-020 In IDLE, if both valids are high, the next state SHALL be OWN of the requester that is not last_served (round-robin).
REQ-021 In OWNx, reqx_ready_o SHALL equal ~full_o, and the other ready output SHALL be 0.
REQ-022 accept = reqx_valid_i & reqx_ready_o in OWNx. On accept, write_enable_o=1, write_address_o=wbin[addr_size-1:0] and write_data_o=reqx_data_i, all combinationally in the same cycle.
REQ-023 On accept, wbin SHALL increment by 1 at the clock edge, wrapping modulo 2^(addr_size+1).
REQ-024 On accept with reqx_last_i=1, the next state SHALL be IDLE and last_served SHALL become x; otherwise the state SHALL stay in OWNx.
REQ-025 A packet SHALL never be interleaved with the other requester's words; the other requester waits until IDLE.
REQ-026 When no accept occurs, write_enable_o SHALL be 0; write_address_o SHALL still show wbin low bits, and write_data_o is don't-care.
REQ-027 full_o SHALL be registered as (Gray(wbin_next) == {~r[addr_size:addr_size-1], r[addr_size-2:0]}), where r = read_to_write_pointer_i and wbin_next is the pointer value after this cycle's accept.
REQ-028 While full_o=1 in OWNx, the block SHALL hold the state and keep ready low. Writing resumes the cycle after full_o falls.
REQ-029 Timing: the first word of a packet is accepted no earlier than 1 cycle after valid rises in IDLE. There SHALL be exactly 1 IDLE cycle between consecutive packets.
REQ-030 A requester deasserting valid mid-packet SHALL NOT release ownership.

Reset
REQ-031 With reset_i=1 at a clock edge, the following SHALL hold: state=IDLE, wbin=0, write_pointer_o=0, full_o=0, last_served=1 (requester 0 has first priority). In the same cycle, ready outputs=0 and write_enable_o=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet with no further writes. It takes priority over any simultaneous accept.

Verification (addr_size=3, data_width=8)
REQ-033 Test: release reset, raise req0_valid with data 0xA5 and last=1, r=0. Required: OWN0 next cycle; write_enable_o=1, address 0, data 0xA5; write_pointer_o becomes 4'b0001; then IDLE.
REQ-034 Test: both valid in IDLE, both sending 2-word packets, repeated. Required: grants go req0, req1, req0, with no interleaving and one IDLE cycle between packets.
REQ-035 Test: write 8 words with r=0. Required: full_o=1 after the 8th accept and write_pointer_o=4'b1100; a 9th word is held with ready=0. Then drive r=Gray(1)=4'b0001; required: full_o falls and the 9th word writes to address 0.
REQ-036 Test: run 20 single-word packets, advancing r to keep the FIFO non-full. Required: wbin wraps 15 to 0; write_pointer_o sequence follows Gray code with exactly one bit changing per accept.
REQ-037 Test: assert reset_i during word 2 of a 4-word req1 packet. Required: next cycle state=IDLE, pointer=0, full_o=0, no write_enable_o; a subsequent req0/req1 tie is granted to req0.
REQ-038 Test: drop req0_valid for 3 cycles mid-packet while req1_valid is high. Required: req1_ready_o stays 0 and req0 resumes ownership.
